// File: rtl/mvu_pkg.sv
// +----------------------------------------------------------------------------+
// | mvu_pkg                                                                    |
// | Shared MVU geometry constants and the detransposer state encoding.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mvu_pkg;

    localparam int N       = 64;
    localparam int BDBANKA = 15;
    localparam int BDBANKW = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } mvu_detrans_state_e;

endpackage

`default_nettype wire

// File: rtl/mvu_rd_lat_pipe.sv
// +----------------------------------------------------------------------------+
// | mvu_rd_lat_pipe                                                            |
// | Delays the RAM read strobe by RD_LAT cycles to mark when data returns.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mvu_rd_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rd_en,
    output logic o_cap_en
);

    generate
        if (RD_LAT == 1) begin : g_single
            logic r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_q <= 1'b0;
                else        r_q <= i_rd_en;
            end
            assign o_cap_en = r_q;
        end else begin : g_chain
            logic [RD_LAT-1:0] r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_q <= '0;
                else        r_q <= {r_q[RD_LAT-2:0], i_rd_en};
            end
            assign o_cap_en = r_q[RD_LAT-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mvu_data_detransposer.sv
// +----------------------------------------------------------------------------+
// | mvu_data_detransposer                                                      |
// | Reads MSB-first bit-planes from MVU RAM and streams out whole elements.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mvu_data_detransposer
    import mvu_pkg::*;
#(
    parameter int NUM_WORDS     = N,
    parameter int XLEN          = 32,
    parameter int MVU_ADDR_LEN  = BDBANKA,
    parameter int MVU_DATA_LEN  = BDBANKW,
    parameter int MAX_DATA_PREC = 16,
    parameter int RD_LAT        = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4:0]              prec,
    input  logic [MVU_ADDR_LEN-1:0] baddr,
    input  logic                    start,
    output logic                    busy,
    output logic                    mvu_rd_en,
    output logic [MVU_ADDR_LEN-1:0] mvu_rd_addr,
    input  logic [MVU_DATA_LEN-1:0] mvu_rd_word,
    output logic [XLEN-1:0]         oword,
    output logic                    ovalid,
    input  logic                    oready,
    output logic                    done,
    output logic                    err
);

    localparam int                    c_iw        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [c_iw-1:0]       c_last_idx  = c_iw'(NUM_WORDS - 1);
    localparam logic [5:0]            c_max_prec  = 6'(MAX_DATA_PREC);

    mvu_detrans_state_e       r_state;
    logic [4:0]               r_prec;
    logic [4:0]               r_rd_cnt;
    logic [4:0]               r_cap_cnt;
    logic [c_iw-1:0]          r_idx;
    logic [MAX_DATA_PREC-1:0] r_acc [NUM_WORDS];

    logic                     w_cap_en;
    logic                     w_prec_bad;
    logic                     w_accept;
    logic [c_iw-1:0]          w_idx_nxt;
    logic [c_iw-1:0]          w_sel_idx;
    logic [XLEN-1:0]          w_sel_word;

    mvu_rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_rd_en  (mvu_rd_en),
        .o_cap_en (w_cap_en)
    );

    assign busy       = (r_state != IDLE);
    assign w_prec_bad = (prec == 5'd0) || ({1'b0, prec} > c_max_prec);
    assign w_accept   = (r_state == IDLE) && start && !w_prec_bad;
    assign w_idx_nxt  = r_idx + c_iw'(1);
    assign w_sel_idx  = (r_state == OUTPUT) ? w_idx_nxt : '0;

    // Zero-extend the selected accumulator to the output width.
    always_comb begin
        w_sel_word                      = '0;
        w_sel_word[MAX_DATA_PREC-1:0]   = r_acc[w_sel_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_prec      <= '0;
            r_rd_cnt    <= '0;
            r_cap_cnt   <= '0;
            r_idx       <= '0;
            mvu_rd_en   <= 1'b0;
            mvu_rd_addr <= '0;
            ovalid      <= 1'b0;
            oword       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (w_cap_en) r_cap_cnt <= r_cap_cnt + 5'd1;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_prec_bad) begin
                            err <= 1'b1;
                        end else begin
                            r_state     <= READ;
                            r_prec      <= prec;
                            r_rd_cnt    <= '0;
                            r_cap_cnt   <= '0;
                            mvu_rd_en   <= 1'b1;
                            mvu_rd_addr <= baddr;
                        end
                    end
                end
                READ: begin
                    if (r_rd_cnt == r_prec - 5'd1) begin
                        mvu_rd_en   <= 1'b0;
                        mvu_rd_addr <= '0;
                        r_state     <= DRAIN;
                    end else begin
                        r_rd_cnt    <= r_rd_cnt + 5'd1;
                        mvu_rd_addr <= mvu_rd_addr + MVU_ADDR_LEN'(1);
                    end
                end
                DRAIN: begin
                    // Every plane has landed in the accumulators once the count matches.
                    if (r_cap_cnt == r_prec) begin
                        r_state <= OUTPUT;
                        r_idx   <= '0;
                        ovalid  <= 1'b1;
                        oword   <= w_sel_word;
                    end
                end
                OUTPUT: begin
                    if (oready) begin
                        if (r_idx == c_last_idx) begin
                            ovalid  <= 1'b0;
                            oword   <= '0;
                            done    <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= w_idx_nxt;
                            oword <= w_sel_word;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Accumulators need no reset: every accepted start clears them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int j = 0; j < NUM_WORDS; j++) r_acc[j] <= '0;
        end else if (w_cap_en) begin
            for (int j = 0; j < NUM_WORDS; j++)
                r_acc[j] <= {r_acc[j][MAX_DATA_PREC-2:0], mvu_rd_word[j]};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mvu_data_detransposer.sv
// +----------------------------------------------------------------------------+
// | tb_mvu_data_detransposer                                                   |
// | Directed self-checking bench for mvu_data_detransposer.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mvu_data_detransposer;

    logic        clk;
    logic        rst_n;
    logic [4:0]  prec;
    logic [14:0] baddr;
    logic        start;
    logic        busy;
    logic        mvu_rd_en;
    logic [14:0] mvu_rd_addr;
    logic [63:0] mvu_rd_word;
    logic [31:0] oword;
    logic        ovalid;
    logic        oready;
    logic        done;
    logic        err;

    int total;
    int bad;

    logic [63:0] mem [32768];
    logic [14:0] rd_q [$];
    logic [31:0] got [$];
    int          done_seen;
    int          err_seen;
    int          busy_seen;
    int          addr_viol;

    mvu_data_detransposer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prec        (prec),
        .baddr       (baddr),
        .start       (start),
        .busy        (busy),
        .mvu_rd_en   (mvu_rd_en),
        .mvu_rd_addr (mvu_rd_addr),
        .mvu_rd_word (mvu_rd_word),
        .oword       (oword),
        .ovalid      (ovalid),
        .oready      (oready),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency RAM model
    always @(posedge clk) begin
        if (mvu_rd_en) mvu_rd_word <= mem[mvu_rd_addr];
        else           mvu_rd_word <= '0;
    end

    always @(negedge clk) begin
        if (rst_n && mvu_rd_en) rd_q.push_back(mvu_rd_addr);
        if (!mvu_rd_en && mvu_rd_addr != 15'd0) addr_viol++;
        if (done) done_seen++;
        if (err)  err_seen++;
        if (busy) busy_seen++;
    end

    task automatic clear_obs();
        rd_q.delete();
        got.delete();
        done_seen = 0;
        err_seen  = 0;
        busy_seen = 0;
    endtask

    task automatic do_start(input logic [4:0] p, input logic [14:0] a);
        @(negedge clk);
        prec  = p;
        baddr = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_job(input logic [4:0] p, input logic [14:0] a,
                           input bit rand_ready, input bit extra_start);
        bit          prev_stall;
        bit          sent;
        bit          finished;
        logic [31:0] prev_word;
        clear_obs();
        prev_stall = 1'b0;
        sent       = 1'b0;
        finished   = 1'b0;
        prev_word  = '0;
        do_start(p, a);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (prev_stall) begin
                total++;
                if (ovalid !== 1'b1 || oword !== prev_word) begin
                    bad++;
                    $display("FAIL stall_hold: ovalid=%b oword=%h required ovalid=1 oword=%h",
                             ovalid, oword, prev_word);
                end
            end
            oready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (extra_start && !sent && got.size() == 1) begin
                start = 1'b1;
                sent  = 1'b1;
            end else begin
                start = 1'b0;
            end
            prev_stall = ovalid && !oready;
            prev_word  = oword;
            if (ovalid && oready) got.push_back(oword);
        end
        start  = 1'b0;
        oready = 1'b1;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL job_timeout: no done within 3000 cycles, words=%0d", got.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        total++;
        if ({busy, mvu_rd_en, mvu_rd_addr, ovalid, done, err, oword} !== '0) begin
            bad++;
            $display("FAIL %s: busy=%b rd_en=%b addr=%h ovalid=%b done=%b err=%b oword=%h required all 0",
                     tag, busy, mvu_rd_en, mvu_rd_addr, ovalid, done, err, oword);
        end
    endtask

    task automatic check_job_common(input string tag, input int n_reads);
        total++;
        if (got.size() != 64) begin
            bad++;
            $display("FAIL %s_words: got %0d words, required 64", tag, got.size());
        end
        total++;
        if (rd_q.size() != n_reads) begin
            bad++;
            $display("FAIL %s_reads: got %0d reads, required %0d", tag, rd_q.size(), n_reads);
        end
        total++;
        if (done_seen != 1) begin
            bad++;
            $display("FAIL %s_done: done pulses=%0d, required 1", tag, done_seen);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: busy=%b, required 0", tag, busy);
        end
    endtask

    task automatic check_onehot_words(input string tag);
        logic [31:0] exp;
        for (int j = 0; j < 64 && j < got.size(); j++) begin
            exp = (j < 16) ? (32'd1 << (15 - j)) : 32'd0;
            total++;
            if (got[j] !== exp) begin
                bad++;
                $display("FAIL %s_elem%0d: oword=%h required %h", tag, j, got[j], exp);
            end
        end
    endtask

    task automatic load_onehot(input logic [14:0] a);
        logic [14:0] addr;
        for (int k = 0; k < 16; k++) begin
            addr      = a + 15'(k);
            mem[addr] = 64'd1 << k;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        prec   = '0;
        baddr  = '0;
        oready = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("after_reset");
    endtask

    task automatic test_basic();
        mem[15'h100] = '1;
        mem[15'h101] = '0;
        run_job(5'd2, 15'h100, 1'b0, 1'b0);
        check_job_common("basic", 2);
        total++;
        if (rd_q.size() == 2 && (rd_q[0] !== 15'h100 || rd_q[1] !== 15'h101)) begin
            bad++;
            $display("FAIL basic_addr: addrs=%h,%h required 0100,0101", rd_q[0], rd_q[1]);
        end
        for (int j = 0; j < 64 && j < got.size(); j++) begin
            total++;
            if (got[j] !== 32'h2) begin
                bad++;
                $display("FAIL basic_elem%0d: oword=%h required 00000002", j, got[j]);
            end
        end
    endtask

    task automatic test_onehot();
        load_onehot(15'h200);
        run_job(5'd16, 15'h200, 1'b0, 1'b0);
        check_job_common("onehot", 16);
        check_onehot_words("onehot");
    endtask

    task automatic test_wrap();
        logic [63:0] m0, m1, m2;
        logic [31:0] exp;
        m0 = 64'hFFFF_FFFF_0000_0000;
        m1 = 64'hFFFF_0000_FFFF_0000;
        m2 = 64'hFF00_FF00_FF00_FF00;
        mem[15'h7FFF] = m0;
        mem[15'h0000] = m1;
        mem[15'h0001] = m2;
        run_job(5'd3, 15'h7FFF, 1'b0, 1'b0);
        check_job_common("wrap", 3);
        total++;
        if (rd_q.size() == 3 && (rd_q[0] !== 15'h7FFF || rd_q[1] !== 15'h0000 || rd_q[2] !== 15'h0001)) begin
            bad++;
            $display("FAIL wrap_addr: addrs=%h,%h,%h required 7fff,0000,0001", rd_q[0], rd_q[1], rd_q[2]);
        end
        for (int j = 0; j < 64 && j < got.size(); j++) begin
            exp = {29'd0, m0[j], m1[j], m2[j]};
            total++;
            if (got[j] !== exp) begin
                bad++;
                $display("FAIL wrap_elem%0d: oword=%h required %h", j, got[j], exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        load_onehot(15'h200);
        run_job(5'd16, 15'h200, 1'b1, 1'b1);
        check_job_common("backpressure", 16);
        check_onehot_words("backpressure");
        total++;
        if (err_seen != 0) begin
            bad++;
            $display("FAIL backpressure_err: err pulses=%0d, required 0", err_seen);
        end
    endtask

    task automatic test_reject();
        logic [4:0] bad_prec [2];
        bad_prec[0] = 5'd0;
        bad_prec[1] = 5'd17;
        for (int i = 0; i < 2; i++) begin
            clear_obs();
            do_start(bad_prec[i], 15'h040);
            total++;
            if (err !== 1'b1) begin
                bad++;
                $display("FAIL reject_err_timing prec=%0d: err=%b required 1", bad_prec[i], err);
            end
            repeat (4) @(negedge clk);
            total++;
            if (err_seen != 1 || busy_seen != 0 || rd_q.size() != 0) begin
                bad++;
                $display("FAIL reject prec=%0d: err pulses=%0d busy cycles=%0d reads=%0d required 1,0,0",
                         bad_prec[i], err_seen, busy_seen, rd_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        mem[15'h300] = '1;
        clear_obs();
        do_start(5'd4, 15'h300);
        @(negedge clk);
        total++;
        if (mvu_rd_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_inread: rd_en=%b required 1", mvu_rd_en);
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_async");
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_mid_hold");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (done_seen != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_abort: done pulses=%0d busy=%b required 0,0", done_seen, busy);
        end
        load_onehot(15'h200);
        run_job(5'd16, 15'h200, 1'b0, 1'b0);
        check_job_common("after_abort", 16);
        check_onehot_words("after_abort");
    endtask

    task automatic test_addr_idle();
        total++;
        if (addr_viol != 0) begin
            bad++;
            $display("FAIL addr_idle_zero: %0d cycles with nonzero addr while rd_en low, required 0", addr_viol);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        addr_viol = 0;
        test_reset();
        test_basic();
        test_onehot();
        test_wrap();
        test_back_to_back();
        test_reject();
        test_reset_mid();
        test_addr_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mvu_data_detransposer.md
MVU_DATA_DETRANSPOSER -- requirements
Module: mvu_data_detransposer

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 64, meaning elements per MVU bit-plane word (one bit per element).
REQ-002 SHALL have parameter XLEN, default 32, meaning output word width.
REQ-003 SHALL have parameter MVU_ADDR_LEN, default 15, meaning MVU RAM address width.
REQ-004 SHALL have parameter MVU_DATA_LEN, default 64, meaning MVU RAM word width, equal to NUM_WORDS.
REQ-005 SHALL have parameter MAX_DATA_PREC, default 16, meaning maximum element precision (at most XLEN).
REQ-006 SHALL have parameter RD_LAT, default 1, meaning fixed MVU RAM read latency in cycles (1 or more).
REQ-007 SHALL have port clk, input, 1 bit: the single clock; one clock domain only.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port prec, input, 5 bits: element precision in bits, sampled on an accepted start.
REQ-010 SHALL have port baddr, input, MVU_ADDR_LEN bits: base address of the MSB plane, sampled on an accepted start.
REQ-011 SHALL have port start, input, 1 bit: single-cycle request.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port mvu_rd_en, output, 1 bit: MVU RAM read strobe.
REQ-014 SHALL have port mvu_rd_addr, output, MVU_ADDR_LEN bits: MVU RAM read address.
REQ-015 SHALL have port mvu_rd_word, input, MVU_DATA_LEN bits: read data, valid RD_LAT cycles after mvu_rd_en.
REQ-016 SHALL have port oword, output, XLEN bits: reconstructed element, zero-extended.
REQ-017 SHALL have port ovalid, output, 1 bit: oword is valid.
REQ-018 SHALL have port oready, input, 1 bit: consumer accepts oword.
REQ-019 SHALL have port done, output, 1 bit: one-cycle pulse when a job completes.
REQ-020 SHALL have port err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-021 SHALL implement the states IDLE, READ, DRAIN and OUTPUT.
REQ-022 SHALL accept start only in IDLE; a start while busy is ignored with no err.
REQ-023 SHALL reject a start in IDLE when prec is 0 or greater than MAX_DATA_PREC: err pulses on the next cycle and the state stays IDLE.
REQ-024 SHALL, on an accepted start in cycle T, go to READ and clear all element accumulators.
REQ-025 SHALL hold mvu_rd_en high in cycles T+1 to T+prec, with mvu_rd_addr = baddr+k in cycle T+1+k, wrapping modulo 2^MVU_ADDR_LEN.
REQ-026 SHALL move from READ to DRAIN after the last read is issued, and from DRAIN to OUTPUT once the last plane has been captured.
REQ-027 SHALL, for each returned plane and for every element j, shift accumulator j left by 1 and load mvu_rd_word[j] into its bit 0; planes arrive MSB first.
REQ-028 SHALL assert ovalid from the first OUTPUT cycle, presenting element 0 first and then elements in ascending order.
REQ-029 SHALL advance to the next element only when ovalid and oready are both high; oword and ovalid stay stable while oready is low.
REQ-030 SHALL, after element NUM_WORDS-1 is accepted, drop ovalid, pulse done in the next cycle and return to IDLE; a new start is accepted in the same cycle done is high.
REQ-031 SHALL drive mvu_rd_addr to 0 whenever mvu_rd_en is low.

Reset
REQ-032 SHALL, when rst_n is low, asynchronously force the state to IDLE and force busy, mvu_rd_en, mvu_rd_addr, ovalid, done, err and oword to 0.
REQ-033 SHALL abort any job when reset is asserted mid-operation; reads in flight are discarded and no done is produced.
REQ-034 SHALL NOT require the accumulator array to be reset, since it is cleared on every accepted start.

Structure
REQ-035 SHALL take the state enum and the defaults NUM_WORDS=N, MVU_ADDR_LEN=BDBANKA and MVU_DATA_LEN=BDBANKW from mvu_pkg.
REQ-036 SHALL place the read-latency delay line in one sub-module, mvu_rd_lat_pipe, which delays mvu_rd_en by RD_LAT cycles to give the capture strobe.

Verification
REQ-037 SHALL pass this test: prec=2, baddr=0x100, planes {MSB=all ones, LSB=all zeros} -> reads at 0x100 and 0x101, 64 words each 0x2, then done.
REQ-038 SHALL pass this test: prec=16, plane k has only bit k set -> element j equals 1<<(15-j) for j<16 and 0 otherwise.
REQ-039 SHALL pass this test: baddr=0x7FFF, prec=3 -> read addresses 0x7FFF, 0x0000, 0x0001.
REQ-040 SHALL pass this test: oready toggled randomly, plus a start issued mid-OUTPUT -> no word lost or duplicated, and the extra start is ignored.
REQ-041 SHALL pass this test: prec=0 and, separately, prec=17 -> err pulses once, busy stays low and no reads are issued.
REQ-042 SHALL pass this test: rst_n asserted during READ, then a fresh start -> all outputs 0 during reset, and the second job's results are correct.
